// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message controller: packs a 32-bit word stream into 512-bit blocks, applies
// padding and length, launches the round core per block and chains H into the digest.
module sha256_msg_ctrl #(
    parameter logic [255:0] H_INIT      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
    parameter int           LEN_BYTES_W = 61
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         in_ready,
    output logic [255:0] core_H_in,
    output logic [511:0] core_M_in,
    output logic         core_input_valid,
    input  logic [255:0] core_H_out,
    input  logic         core_output_valid,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    state_e                   state_q, state_d;
    logic [4:0]               word_cnt_q, word_cnt_d;
    logic [LEN_BYTES_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic                     pad_pending_q, pad_pending_d;
    logic                     final_blk_q, final_blk_d;
    logic                     msg_done_q, msg_done_d;
    logic [0:15][31:0]        msg_buf_q, msg_buf_d;
    logic                     in_ready_q, in_ready_d;
    logic [255:0]             core_h_in_q, core_h_in_d;
    logic [511:0]             core_m_in_q, core_m_in_d;
    logic                     core_input_valid_q, core_input_valid_d;
    logic [255:0]             digest_q, digest_d;
    logic                     digest_valid_q, digest_valid_d;
    logic                     busy_q, busy_d;

    logic                     accept;
    logic [31:0]              fill_word;
    logic [2:0]               add_bytes;
    logic [63:0]              bit_len;

    assign accept  = in_valid && in_ready_q;
    assign bit_len = 64'({byte_cnt_q, 3'b000});

    always_comb begin
        state_d            = state_q;
        word_cnt_d         = word_cnt_q;
        byte_cnt_d         = byte_cnt_q;
        pad_pending_d      = pad_pending_q;
        final_blk_d        = final_blk_q;
        msg_done_d         = msg_done_q;
        msg_buf_d          = msg_buf_q;
        core_h_in_d        = core_h_in_q;
        core_m_in_d        = core_m_in_q;
        core_input_valid_d = 1'b0;
        digest_d           = digest_q;
        digest_valid_d     = digest_valid_q;
        busy_d             = busy_q;
        fill_word          = in_data;
        add_bytes          = 3'd4;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    busy_d     = 1'b1;
                    word_cnt_d = word_cnt_q + 5'd1;
                    if (in_last && (in_bytes != 2'd0)) begin
                        // Partial last word carries the 0x80 terminator right after its data.
                        add_bytes     = {1'b0, in_bytes};
                        pad_pending_d = 1'b0;
                        case (in_bytes)
                            2'd1:    fill_word = {in_data[31:24], 8'h80, 16'h0000};
                            2'd2:    fill_word = {in_data[31:16], 8'h80, 8'h00};
                            default: fill_word = {in_data[31:8], 8'h80};
                        endcase
                    end else begin
                        pad_pending_d = in_last;
                    end
                    msg_buf_d[word_cnt_q[3:0]] = fill_word;
                    byte_cnt_d = byte_cnt_q + LEN_BYTES_W'(add_bytes);
                    if (in_last) begin
                        msg_done_d = 1'b1;
                        state_d    = (word_cnt_q == 5'd15) ? S_LAUNCH : S_PAD;
                    end else if (word_cnt_q == 5'd15) begin
                        state_d = S_LAUNCH;
                    end
                end
            end

            S_PAD: begin
                word_cnt_d = word_cnt_q + 5'd1;
                if (word_cnt_q == 5'd14) begin
                    if (pad_pending_q) begin
                        msg_buf_d[14] = PAD_WORD;
                        pad_pending_d = 1'b0;
                    end else begin
                        msg_buf_d[14] = bit_len[63:32];
                        final_blk_d   = 1'b1;
                    end
                end else if (word_cnt_q == 5'd15) begin
                    if (final_blk_q) begin
                        msg_buf_d[15] = bit_len[31:0];
                    end else if (pad_pending_q) begin
                        msg_buf_d[15] = PAD_WORD;
                        pad_pending_d = 1'b0;
                    end else begin
                        msg_buf_d[15] = 32'h0;
                    end
                    state_d = S_LAUNCH;
                end else begin
                    msg_buf_d[word_cnt_q[3:0]] = pad_pending_q ? PAD_WORD : 32'h0;
                    pad_pending_d              = 1'b0;
                end
            end

            S_LAUNCH: begin
                core_m_in_d        = msg_buf_q;
                core_input_valid_d = 1'b1;
                state_d            = S_WAIT;
            end

            S_WAIT: begin
                if (core_output_valid) begin
                    core_h_in_d = core_H_out;
                    word_cnt_d  = 5'd0;
                    if (final_blk_q) begin
                        digest_d       = core_H_out;
                        digest_valid_d = 1'b1;
                        state_d        = S_DONE;
                    end else if (msg_done_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end

            S_DONE: begin
                if (digest_ready) begin
                    digest_valid_d = 1'b0;
                    core_h_in_d    = H_INIT;
                    byte_cnt_d     = '0;
                    word_cnt_d     = 5'd0;
                    pad_pending_d  = 1'b0;
                    final_blk_d    = 1'b0;
                    msg_done_d     = 1'b0;
                    busy_d         = 1'b0;
                    state_d        = S_FILL;
                end
            end

            default: state_d = S_FILL;
        endcase

        // in_ready is registered, so it is derived from the next-cycle state.
        in_ready_d = (state_d == S_FILL) && (word_cnt_d < 5'd16);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= S_FILL;
            word_cnt_q         <= 5'd0;
            byte_cnt_q         <= '0;
            pad_pending_q      <= 1'b0;
            final_blk_q        <= 1'b0;
            msg_done_q         <= 1'b0;
            in_ready_q         <= 1'b0;
            core_h_in_q        <= H_INIT;
            core_m_in_q        <= '0;
            core_input_valid_q <= 1'b0;
            digest_q           <= '0;
            digest_valid_q     <= 1'b0;
            busy_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            word_cnt_q         <= word_cnt_d;
            byte_cnt_q         <= byte_cnt_d;
            pad_pending_q      <= pad_pending_d;
            final_blk_q        <= final_blk_d;
            msg_done_q         <= msg_done_d;
            in_ready_q         <= in_ready_d;
            core_h_in_q        <= core_h_in_d;
            core_m_in_q        <= core_m_in_d;
            core_input_valid_q <= core_input_valid_d;
            digest_q           <= digest_d;
            digest_valid_q     <= digest_valid_d;
            busy_q             <= busy_d;
        end
    end

    // NOTE: the block buffer has no reset; every slot is rewritten by FILL/PAD before LAUNCH reads it.
    always_ff @(posedge clk) begin
        msg_buf_q <= msg_buf_d;
    end

    assign in_ready         = in_ready_q;
    assign core_H_in        = core_h_in_q;
    assign core_M_in        = core_m_in_q;
    assign core_input_valid = core_input_valid_q;
    assign digest           = digest_q;
    assign digest_valid     = digest_valid_q;
    assign busy             = busy_q;

endmodule
